// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.

// One combinational read port: stored data/valid, optional forwarding, zero-register override.
module reg_file_sb_rdport #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int NREGS      = 2**ADDR_WIDTH
) (
    input  logic [NREGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic [NREGS-1:0]                 pend,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic                             byp_en,
    input  logic [ADDR_WIDTH-1:0]            byp_addr,
    input  logic [DATA_WIDTH-1:0]            byp_data,
    output logic [DATA_WIDTH-1:0]            data,
    output logic                             valid
);
    always_comb begin
        data  = regs[addr];
        valid = ~pend[addr];
        if (byp_en && (byp_addr == addr)) begin
            data  = byp_data;
            valid = 1'b1;
        end
        // Register 0 is never written when hardwired, but force it anyway.
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data  = '0;
            valid = 1'b1;
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic signed [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0]        INADDRESS,
    input  logic                         WRITE,
    input  logic                         RESERVE,
    input  logic [ADDR_WIDTH-1:0]        RESADDRESS,
    input  logic [ADDR_WIDTH-1:0]        OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0]        OUT2ADDRESS,
    output logic signed [DATA_WIDTH-1:0] OUT1,
    output logic signed [DATA_WIDTH-1:0] OUT2,
    output logic                         OUT1VALID,
    output logic                         OUT2VALID,
    output logic [ADDR_WIDTH:0]          PENDCOUNT
);
    localparam int NREGS = 2**ADDR_WIDTH;
    localparam int NPORTS = 2;

    logic [NREGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NREGS-1:0]                 pend, pend_nxt;
    logic [ADDR_WIDTH:0]              pcount, pcount_nxt;
    logic                             wr_ok, rs_ok, inc, dec;
    logic                             byp_en;

    assign wr_ok = WRITE   && !((ZERO_REG != 0) && (INADDRESS  == '0));
    assign rs_ok = RESERVE && !((ZERO_REG != 0) && (RESADDRESS == '0));

    // Counter tracks popcount(pend): a fresh reservation adds one, a write retiring
    // a reservation removes one unless the same register is re-reserved this cycle.
    assign inc = rs_ok && !pend[RESADDRESS];
    assign dec = wr_ok && pend[INADDRESS] && !(rs_ok && (RESADDRESS == INADDRESS));

    always_comb begin
        pend_nxt = pend;
        if (wr_ok) pend_nxt[INADDRESS]  = 1'b0;
        if (rs_ok) pend_nxt[RESADDRESS] = 1'b1;
    end

    always_comb begin
        pcount_nxt = pcount;
        case ({inc, dec})
            2'b10:   pcount_nxt = pcount + (ADDR_WIDTH+1)'(1);
            2'b01:   pcount_nxt = pcount - (ADDR_WIDTH+1)'(1);
            default: pcount_nxt = pcount;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs   <= '0;
            pend   <= '0;
            pcount <= '0;
        end else begin
            if (wr_ok) regs[INADDRESS] <= IN;
            pend   <= pend_nxt;
            pcount <= pcount_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_en = wr_ok && !RESET;
`else
    assign byp_en = 1'b0;
`endif

    logic [NPORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NPORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NPORTS-1:0]                 rd_valid;

    assign rd_addr = {OUT2ADDRESS, OUT1ADDRESS};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        reg_file_sb_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .NREGS     (NREGS)
        ) u_rd (
            .regs    (regs),
            .pend    (pend),
            .addr    (rd_addr[p]),
            .byp_en  (byp_en),
            .byp_addr(INADDRESS),
            .byp_data(IN),
            .data    (rd_data[p]),
            .valid   (rd_valid[p])
        );
    end

    assign OUT1      = rd_data[0];
    assign OUT2      = rd_data[1];
    assign OUT1VALID = rd_valid[0];
    assign OUT2VALID = rd_valid[1];
    assign PENDCOUNT = pcount;
endmodule
